// File: rtl/stream_demux_1_4_if.sv
// Stream bundle for the 1:4 demux: one valid/ready input, four buffered valid/ready outputs
// with per-channel delivered-item counters.
interface stream_demux_1_4_if #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       in_data;
  logic [1:0]         in_sel;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*W-1:0]     out_data;
  logic [4*CNT_W-1:0] out_count;

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, out_count
  );

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/stream_demux_1_4.sv
// Steers each accepted input item into one of four one-entry output buffers chosen by in_sel;
// each channel counts the items its consumer has taken.
module stream_demux_1_4 #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic                clk,
  input logic                rst,
  stream_demux_1_4_if.slave  io_bus
);

  logic [3:0]       r_valid;
  logic [W-1:0]     r_data  [4];
  logic [CNT_W-1:0] r_count [4];

  logic       w_in_ready;
  logic       w_acc;
  logic [3:0] w_load;
  logic [3:0] w_dlv;

  // Ready depends only on the selected buffer; a draining buffer can be refilled same cycle.
  always_comb begin
    w_in_ready = !r_valid[io_bus.in_sel] | io_bus.out_ready[io_bus.in_sel];
    w_acc      = io_bus.in_valid & w_in_ready;
    w_load     = '0;
    if (w_acc) begin
      w_load[io_bus.in_sel] = 1'b1;
    end
    w_dlv = r_valid & io_bus.out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int k = 0; k < 4; k++) begin
        r_data[k]  <= '0;
        r_count[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_load[k]) begin
          r_valid[k] <= 1'b1;
          r_data[k]  <= io_bus.in_data;
        end else if (w_dlv[k]) begin
          r_valid[k] <= 1'b0;
        end
        if (w_dlv[k]) begin
          r_count[k] <= r_count[k] + CNT_W'(1);
        end
      end
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = r_valid;

  for (genvar k = 0; k < 4; k++) begin : g_out
    assign io_bus.out_data[k*W +: W]          = r_data[k];
    assign io_bus.out_count[k*CNT_W +: CNT_W] = r_count[k];
  end

endmodule
